// File: rtl/stb_controller.sv
// Store-buffer control FSM: accepts LSU stores, drains entries to the DCache,
// handles fence-style flush and flags a DCache that stops acknowledging.
module stb_controller #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lsudbus2stb_req,
  output logic stb2lsudbus_ack,
  input  logic dcache2stb_ack,
  input  logic stb_empty,
  input  logic stb_full,
  input  logic stb_flush_req,
  output logic stb_flush_done,
  output logic wr_en,
  output logic r_en,
  output logic rd_sel,
  output logic stb_timeout_err
);

  localparam int unsigned TO_CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  flush_pending_q, flush_pending_d;
  logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic                  err_q, err_d;
  logic                  pop_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      flush_pending_q <= 1'b0;
      to_cnt_q        <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      to_cnt_q        <= to_cnt_d;
      err_q           <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    to_cnt_d        = '0;
    err_d           = err_q;
    pop_c           = 1'b0;
    rd_sel          = 1'b0;
    r_en            = 1'b0;
    wr_en           = 1'b0;
    stb2lsudbus_ack = 1'b0;
    stb_flush_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!stb_empty) state_d = REQ;
      end
      REQ: begin
        rd_sel = 1'b1;
        if (dcache2stb_ack) begin
          pop_c   = 1'b1;
          r_en    = 1'b1;
          state_d = RELEASE;
        end else if (to_cnt_q == TO_CNT_W'(ACK_TIMEOUT)) begin
          to_cnt_d = to_cnt_q;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
      end
      // One-cycle gap between DCache requests; empty here is post-pop.
      RELEASE: begin
        state_d = stb_empty ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase

    if (to_cnt_d == TO_CNT_W'(ACK_TIMEOUT)) err_d = 1'b1;

    stb_flush_done = flush_pending_q && stb_empty && (state_q == IDLE);
    if (stb_flush_done)     flush_pending_d = 1'b0;
    else if (stb_flush_req) flush_pending_d = 1'b1;

    // Pop wins the single occupancy update per cycle; rst_n keeps ack low in reset.
    wr_en = rst_n && lsudbus2stb_req && !stb_full && !pop_c
            && !stb_flush_req && !flush_pending_q;
    stb2lsudbus_ack = wr_en;
  end

  assign stb_timeout_err = err_q;

endmodule
